// File: rtl/inst_bundle_splitter.sv
// -----------------------------------------------------------------------------
// inst_bundle_splitter
//
// Purpose:
//    Takes one fetch bundle of N_SLOTS instruction words with a per-slot valid
//    mask, holds it, and presents the valid slots one per cycle, lowest slot
//    first, to a downstream instruction FIFO. Each presented word carries its
//    own PC, which is the bundle PC plus 4 bytes per slot.
//
// Ports:
//    clk        in   sole clock, rising edge
//    rst_aL     in   asynchronous active-low reset
//    flush      in   synchronous discard of held slots and of any offered bundle
//    valid_in   in   upstream bundle valid
//    ready_in   out  splitter accepts a bundle this cycle
//    bundle_in  in   N_SLOTS*INST_WIDTH bundle, slot i at [i*INST_WIDTH +: INST_WIDTH]
//    mask_in    in   per-slot valid mask
//    pc_in      in   PC of slot 0
//    valid_out  out  instruction presented downstream
//    ready_out  in   downstream can enqueue
//    inst_out   out  presented instruction
//    pc_out     out  PC of presented instruction
//    stall_cnt  out  16-bit saturating stall counter (optional)
//
// Configuration:
//    INST_BUNDLE_SPLITTER_STALL_CTR_EN -- when defined, adds stall_cnt, which
//    counts cycles with valid_out && !ready_out, saturates at 16'hFFFF, is
//    cleared only by reset (not by flush).
// -----------------------------------------------------------------------------
module inst_bundle_splitter #(
   parameter int INST_WIDTH = 32,
   parameter int N_SLOTS    = 2,
   parameter int PC_WIDTH   = 32
) (
   input  logic                          clk,
   input  logic                          rst_aL,
   input  logic                          flush,
   input  logic                          valid_in,
   output logic                          ready_in,
   input  logic [N_SLOTS*INST_WIDTH-1:0] bundle_in,
   input  logic [N_SLOTS-1:0]            mask_in,
   input  logic [PC_WIDTH-1:0]           pc_in,
   output logic                          valid_out,
   input  logic                          ready_out,
   output logic [INST_WIDTH-1:0]         inst_out,
   output logic [PC_WIDTH-1:0]           pc_out
`ifdef INST_BUNDLE_SPLITTER_STALL_CTR_EN
   ,
   output logic [15:0]                   stall_cnt
`endif
);

   localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   // Holding register: remaining-slot mask, bundle and bundle PC
   logic [N_SLOTS-1:0]            rem_q, rem_d;
   logic [N_SLOTS*INST_WIDTH-1:0] bundle_q, bundle_d;
   logic [PC_WIDTH-1:0]           pc_q, pc_d;

   logic [SLOT_W-1:0]             slot_s;
   logic                          rem_busy_s;
   logic                          one_left_s;
   logic                          accept_s;
   logic                          pop_s;
   logic [N_SLOTS-1:0]            slot_bit_s;

   // Lowest set bit of rem selects the presented slot; scanning downward lets
   // the lowest index overwrite any higher one
   always_comb begin
      slot_s = {SLOT_W{1'b0}};
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (rem_q[i]) begin
            slot_s = SLOT_W'(i);
         end else begin
            slot_s = slot_s;
         end
      end
   end

   assign rem_busy_s = (rem_q != {N_SLOTS{1'b0}});
   // Exactly one bit set: non-zero and clearing the lowest bit leaves zero
   assign one_left_s = rem_busy_s &&
                       ((rem_q & (rem_q - {{(N_SLOTS-1){1'b0}}, 1'b1})) == {N_SLOTS{1'b0}});
   assign slot_bit_s = {{(N_SLOTS-1){1'b0}}, 1'b1} << slot_s;

   // Handshake outputs are combinational: a flush must suppress them the same cycle
   assign ready_in  = !flush && (!rem_busy_s || (one_left_s && ready_out));
   assign valid_out = rem_busy_s && !flush;
   assign accept_s  = valid_in && ready_in;
   assign pop_s     = valid_out && ready_out;

   // Presented word and its PC (PC wraps naturally by truncation)
   assign inst_out = bundle_q[slot_s*INST_WIDTH +: INST_WIDTH];
   assign pc_out   = pc_q + (PC_WIDTH'(slot_s) << 2);

   // Next-state for the holding register; flush has priority, and an accept
   // on the last-slot pop replaces the bundle with no bubble
   always_comb begin
      rem_d    = rem_q;
      bundle_d = bundle_q;
      pc_d     = pc_q;
      if (flush) begin
         rem_d = {N_SLOTS{1'b0}};
      end else if (accept_s) begin
         rem_d    = mask_in;
         bundle_d = bundle_in;
         pc_d     = pc_in;
      end else if (pop_s) begin
         rem_d = rem_q & ~slot_bit_s;
      end else begin
         rem_d = rem_q;
      end
   end

   // Holding register state; reset discards remaining slots immediately
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         rem_q    <= {N_SLOTS{1'b0}};
         bundle_q <= {(N_SLOTS*INST_WIDTH){1'b0}};
         pc_q     <= {PC_WIDTH{1'b0}};
      end else begin
         rem_q    <= rem_d;
         bundle_q <= bundle_d;
         pc_q     <= pc_d;
      end
   end

`ifdef INST_BUNDLE_SPLITTER_STALL_CTR_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Stall count saturates rather than wrapping
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (valid_out && !ready_out && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register; flush intentionally does not clear it
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_bundle_splitter.sv
module tb_inst_bundle_splitter;

   logic        clk;
   logic        rst_aL;
   logic        flush;
   logic        valid_in;
   logic        ready_in;
   logic [63:0] bundle_in;
   logic [1:0]  mask_in;
   logic [31:0] pc_in;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
`ifdef INST_BUNDLE_SPLITTER_STALL_CTR_EN
   logic [15:0] stall_cnt;
`endif

   int checks;
   int errors;

   inst_bundle_splitter #(.INST_WIDTH(32), .N_SLOTS(2), .PC_WIDTH(32)) dut (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .bundle_in (bundle_in),
      .mask_in   (mask_in),
      .pc_in     (pc_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .inst_out  (inst_out),
      .pc_out    (pc_out)
`ifdef INST_BUNDLE_SPLITTER_STALL_CTR_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] b, input logic [1:0] m, input logic [31:0] p);
      valid_in  = v;
      bundle_in = b;
      mask_in   = m;
      pc_in     = p;
   endtask

   task automatic test_reset();
      rst_aL = 1'b1; flush = 1'b0; ready_out = 1'b1;
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      #1 rst_aL = 1'b0;
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_out); end
      checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", ready_in); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst_out); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_out); end
      checks++; if (dut.rem_q !== 2'b00) begin errors++; $display("FAIL reset_rem got %b exp 00", dut.rem_q); end
      next_cycle();
      rst_aL = 1'b1;
      next_cycle();
   endtask

   // {B,A} @0x100 then {D,C} @0x300 offered while B is presented
   task automatic test_full();
      logic [31:0] exp_i [4];
      logic [31:0] exp_p [4];
      exp_i[0] = 32'hAAAA0001; exp_i[1] = 32'hBBBB0002; exp_i[2] = 32'hCCCC0003; exp_i[3] = 32'hDDDD0004;
      exp_p[0] = 32'h100; exp_p[1] = 32'h104; exp_p[2] = 32'h300; exp_p[3] = 32'h304;
      drive(1'b1, {32'hBBBB0002, 32'hAAAA0001}, 2'b11, 32'h100);
      @(negedge clk);
      checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL full_c0_ready got %0b exp 1", ready_in); end
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) drive(1'b1, {32'hDDDD0004, 32'hCCCC0003}, 2'b11, 32'h300);
         else drive(1'b0, 64'd0, 2'b00, 32'd0);
         @(negedge clk);
         checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL full_c%0d_valid got %0b exp 1", c+1, valid_out); end
         checks++; if (inst_out !== exp_i[c]) begin errors++; $display("FAIL full_c%0d_inst got %h exp %h", c+1, inst_out, exp_i[c]); end
         checks++; if (pc_out !== exp_p[c]) begin errors++; $display("FAIL full_c%0d_pc got %h exp %h", c+1, pc_out, exp_p[c]); end
         if (c == 0 || c == 2) begin
            checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL full_c%0d_ready got %0b exp 0", c+1, ready_in); end
         end else begin
            checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL full_c%0d_ready got %0b exp 1", c+1, ready_in); end
         end
         next_cycle();
      end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL full_c5_valid got %0b exp 0", valid_out); end
      next_cycle();
   endtask

   task automatic test_sparse();
      drive(1'b1, {32'hFFFF0006, 32'hEEEE0005}, 2'b10, 32'h200);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      @(negedge clk);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL sparse_valid got %0b exp 1", valid_out); end
      checks++; if (inst_out !== 32'hFFFF0006) begin errors++; $display("FAIL sparse_inst got %h exp FFFF0006", inst_out); end
      checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL sparse_pc got %h exp 204", pc_out); end
      next_cycle();
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sparse_done_valid got %0b exp 0", valid_out); end
      // Empty mask: accepted but produces nothing
      drive(1'b1, {32'h12345678, 32'h9ABCDEF0}, 2'b00, 32'h280);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL zero_mask_valid_c%0d got %0b exp 0", c, valid_out); end
         checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL zero_mask_ready_c%0d got %0b exp 1", c, ready_in); end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, {32'h22220008, 32'h11110007}, 2'b11, 32'h400);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      ready_out = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (inst_out !== 32'h11110007) begin errors++; $display("FAIL bp_hold%0d_inst got %h exp 11110007", c, inst_out); end
         checks++; if (pc_out !== 32'h400) begin errors++; $display("FAIL bp_hold%0d_pc got %h exp 400", c, pc_out); end
         checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready got %0b exp 0", c, ready_in); end
         next_cycle();
      end
      ready_out = 1'b1;
      @(negedge clk);
      checks++; if (inst_out !== 32'h11110007) begin errors++; $display("FAIL bp_rel0_inst got %h exp 11110007", inst_out); end
      next_cycle();
      @(negedge clk);
      checks++; if (inst_out !== 32'h22220008) begin errors++; $display("FAIL bp_rel1_inst got %h exp 22220008", inst_out); end
      checks++; if (pc_out !== 32'h404) begin errors++; $display("FAIL bp_rel1_pc got %h exp 404", pc_out); end
      next_cycle();
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %0b exp 0", valid_out); end
`ifdef INST_BUNDLE_SPLITTER_STALL_CTR_EN
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got %0d exp 3", stall_cnt); end
`endif
      next_cycle();
   endtask

   task automatic test_flush();
      drive(1'b1, {32'h44440010, 32'h33330009}, 2'b11, 32'h500);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      next_cycle();
      // Slot 0 consumed; flush while a new bundle is offered
      flush = 1'b1;
      drive(1'b1, {32'h66660012, 32'h55550011}, 2'b11, 32'h600);
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_now_valid got %0b exp 0", valid_out); end
      checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL flush_now_ready got %0b exp 0", ready_in); end
      next_cycle();
      flush = 1'b0;
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_next_valid got %0b exp 0", valid_out); end
      checks++; if (dut.rem_q !== 2'b00) begin errors++; $display("FAIL flush_rem got %b exp 00", dut.rem_q); end
      checks++; if (inst_out !== 32'h33330009) begin errors++; $display("FAIL flush_not_captured_inst got %h exp 33330009", inst_out); end
      checks++; if (pc_out !== 32'h500) begin errors++; $display("FAIL flush_not_captured_pc got %h exp 500", pc_out); end
      next_cycle();
   endtask

   task automatic test_async_reset();
      drive(1'b1, {32'h88880014, 32'h77770013}, 2'b11, 32'h700);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      @(negedge clk);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %0b exp 1", valid_out); end
      #1 rst_aL = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b exp 0", valid_out); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL areset_inst got %h exp 0", inst_out); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL areset_pc got %h exp 0", pc_out); end
      next_cycle();
      rst_aL = 1'b1;
      test_full();
   endtask

   task automatic test_pc_wrap();
      drive(1'b1, {32'hBEEF0002, 32'hBEEF0001}, 2'b11, 32'hFFFFFFFC);
      next_cycle();
      drive(1'b0, 64'd0, 2'b00, 32'd0);
      @(negedge clk);
      checks++; if (pc_out !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp FFFFFFFC", pc_out); end
      next_cycle();
      @(negedge clk);
      checks++; if (inst_out !== 32'hBEEF0002) begin errors++; $display("FAIL wrap_inst1 got %h exp BEEF0002", inst_out); end
      checks++; if (pc_out !== 32'h00000000) begin errors++; $display("FAIL wrap_pc1 got %h exp 00000000", pc_out); end
      next_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full();
      test_sparse();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_pc_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
